// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one registered-operand ALU among NREQ valid/ready requesters
module alu #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       op,
  output logic [WIDTH-1:0] y,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);
  logic             sub, arith;
  logic [WIDTH-1:0] bb;
  logic [WIDTH:0]   s;
  assign sub      = op == 4'h1;
  assign arith    = op[3:1] == 3'd0;
  assign bb       = sub ? ~b : b;
  assign s        = {1'b0, a} + {1'b0, bb} + {{WIDTH{1'b0}}, sub};
  assign y        = arith ? s[WIDTH-1:0] : op == 4'h2 ? a & b : op == 4'h3 ? a | b : op == 4'h4 ? a ^ b : a;
  // SUB carry is the adder carry-out, i.e. 1 means no borrow
  assign carry    = arith & s[WIDTH];
  assign overflow = arith & (a[WIDTH-1] == bb[WIDTH-1]) & (y[WIDTH-1] != a[WIDTH-1]);
  assign zero     = ~|y;
  assign negative = y[WIDTH-1];
endmodule

module alu_arbiter #(
  parameter  int WIDTH = 32,
  parameter  int NREQ  = 4,
  localparam int IDW   = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  input  logic [NREQ*4-1:0]     req_op,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_y,
  output logic                  rsp_carry,
  output logic                  rsp_overflow,
  output logic                  rsp_zero,
  output logic                  rsp_negative,
  output logic                  busy
);
  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;
  state_t           state, state_nx;
  logic [IDW-1:0]   last, grant, idx, rid;
  logic             hit, arb, acc;
  logic [WIDTH-1:0] ra, rb, y;
  logic [3:0]       rop;
  logic             c, v, z, n;
  // walk downwards so the nearest requester after last wins
  always_comb begin
    idx   = '0;
    grant = last;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IDW'((int'(last) + k) % NREQ);
      if (req_valid[idx]) grant = idx;
    end
  end
  assign hit       = |req_valid;
  assign arb       = state == IDLE || (state == RESP && rsp_ready);
  assign acc       = arb && hit;
  assign req_ready = acc ? NREQ'(1) << grant : '0;
  assign state_nx  = state == EXEC ? RESP : arb ? (hit ? EXEC : IDLE) : state;
  assign busy      = state != IDLE;
  alu #(.WIDTH(WIDTH)) u_alu (
    .a(ra), .b(rb), .op(rop), .y(y),
    .carry(c), .overflow(v), .zero(z), .negative(n)
  );
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= IDLE;
      last         <= IDW'(NREQ - 1);
      ra           <= '0;
      rb           <= '0;
      rop          <= '0;
      rid          <= '0;
      rsp_valid    <= 1'b0;
      rsp_id       <= '0;
      rsp_y        <= '0;
      rsp_carry    <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_zero     <= 1'b0;
      rsp_negative <= 1'b0;
    end else begin
      state <= state_nx;
      if (acc) begin
        ra   <= req_a[int'(grant)*WIDTH +: WIDTH];
        rb   <= req_b[int'(grant)*WIDTH +: WIDTH];
        rop  <= req_op[int'(grant)*4 +: 4];
        rid  <= grant;
        last <= grant;
      end
      if (state == EXEC) begin
        rsp_valid    <= 1'b1;
        rsp_id       <= rid;
        rsp_y        <= y;
        rsp_carry    <= c;
        rsp_overflow <= v;
        rsp_zero     <= z;
        rsp_negative <= n;
      end else if (arb) rsp_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: vector table, directed corner sequences and a randomized transaction-level model
module tb_alu_arbiter;
  localparam int W = 32, N = 4, IDW = 2;
  logic clk = 0, rst_n = 0;
  logic [N-1:0] req_valid, req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic [N*4-1:0] req_op;
  logic rsp_valid, rsp_ready;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0] rsp_y;
  logic rsp_carry, rsp_overflow, rsp_zero, rsp_negative, busy;
  int checks = 0, failures = 0;
  typedef struct packed {logic c, v, z, n; logic [W-1:0] y;} res_t;
  typedef struct {int r; logic [W-1:0] a, b; logic [3:0] op; res_t e;} vec_t;
  vec_t vt[10];
  always #5 clk = ~clk;
  alu_arbiter #(.WIDTH(W), .NREQ(N)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_y(rsp_y), .rsp_carry(rsp_carry),
    .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero), .rsp_negative(rsp_negative),
    .busy(busy)
  );
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask
  task automatic chk_rsp(input string nm, input int id, input res_t e);
    chk({nm, "_id"}, 64'(rsp_id), 64'(id));
    chk({nm, "_y"}, 64'(rsp_y), 64'(e.y));
    chk({nm, "_flags"}, 64'({rsp_carry, rsp_overflow, rsp_zero, rsp_negative}), 64'({e.c, e.v, e.z, e.n}));
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic put(input int r, input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
    req_a[r*W +: W] = a;
    req_b[r*W +: W] = b;
    req_op[r*4 +: 4] = op;
    req_valid[r] = 1'b1;
  endtask
  task automatic do_reset();
    rst_n = 0;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    req_op = '0;
    rsp_ready = 0;
    step();
    step();
    rst_n = 1;
  endtask
  function automatic res_t ref_alu(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] op);
    res_t r;
    logic [W:0] t;
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0;
    case (op)
      4'h0: begin
        r.y = a + b;
        t = {1'b0, a} + {1'b0, b};
        r.c = t[W];
        s = sa + sb;
        r.v = s != longint'($signed(r.y));
      end
      4'h1: begin
        r.y = a - b;
        r.c = a >= b;
        s = sa - sb;
        r.v = s != longint'($signed(r.y));
      end
      4'h2: r.y = a & b;
      4'h3: r.y = a | b;
      4'h4: r.y = a ^ b;
      default: r.y = a;
    endcase
    r.z = r.y == 0;
    r.n = r.y[W-1];
    return r;
  endfunction
  function automatic logic [W-1:0] rnd_opnd();
    int s;
    s = $urandom_range(0, 7);
    return s == 0 ? 32'h0 : s == 1 ? 32'h7FFF_FFFF : s == 2 ? 32'h8000_0000 : s == 3 ? 32'hFFFF_FFFF : $urandom;
  endfunction
  initial begin
    int ph, mlast, mid, mpid, g;
    logic can;
    res_t mres, mpend;
    vt[0] = '{0, 32'd5, 32'd3, 4'h0, '{1'b0, 1'b0, 1'b0, 1'b0, 32'd8}};
    vt[1] = '{2, 32'h7FFF_FFFF, 32'd1, 4'h0, '{1'b0, 1'b1, 1'b0, 1'b1, 32'h8000_0000}};
    vt[2] = '{1, 32'd7, 32'd7, 4'h1, '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0}};
    vt[3] = '{3, 32'hFFFF_FFFF, 32'd1, 4'h0, '{1'b1, 1'b0, 1'b1, 1'b0, 32'h0}};
    vt[4] = '{0, 32'd3, 32'd5, 4'h1, '{1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFE}};
    vt[5] = '{1, 32'h8000_0000, 32'd1, 4'h1, '{1'b1, 1'b1, 1'b0, 1'b0, 32'h7FFF_FFFF}};
    vt[6] = '{2, 32'hF0F0, 32'hFF00, 4'h2, '{1'b0, 1'b0, 1'b0, 1'b0, 32'hF000}};
    vt[7] = '{3, 32'hF0F0, 32'h0F0F, 4'h3, '{1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFF}};
    vt[8] = '{0, 32'hAAAA, 32'hAAAA, 4'h4, '{1'b0, 1'b0, 1'b1, 1'b0, 32'h0}};
    vt[9] = '{1, 32'h1234_5678, 32'h9, 4'h9, '{1'b0, 1'b0, 1'b0, 1'b0, 32'h1234_5678}};
    do_reset();
    #1;
    chk("rst_busy", 64'(busy), 0);
    chk("rst_valid", 64'(rsp_valid), 0);
    chk("rst_ready", 64'(req_ready), 0);
    chk_rsp("rst", 0, '0);
    rsp_ready = 1;
    foreach (vt[i]) begin
      put(vt[i].r, vt[i].a, vt[i].b, vt[i].op);
      #1;
      chk("tbl_ready", 64'(req_ready), 64'(1) << vt[i].r);
      step();
      req_valid = '0;
      #1;
      chk("tbl_exec_valid", 64'(rsp_valid), 0);
      chk("tbl_exec_busy", 64'(busy), 1);
      step();
      chk("tbl_rsp_valid", 64'(rsp_valid), 1);
      chk_rsp("tbl", vt[i].r, vt[i].e);
      step();
      chk("tbl_done_valid", 64'(rsp_valid), 0);
      chk("tbl_done_busy", 64'(busy), 0);
    end
    // contention: every requester always valid, responses back-to-back
    do_reset();
    rsp_ready = 1;
    for (int i = 0; i < N; i++) put(i, 32'(10 * (i + 1)), 32'(i), 4'h0);
    #1;
    for (int k = 0; k < 5; k++) begin
      chk("cont_grant", 64'(req_ready), 64'(1) << (k % N));
      step();
      chk("cont_exec_valid", 64'(rsp_valid), 0);
      chk("cont_exec_ready", 64'(req_ready), 0);
      step();
      chk("cont_rsp_valid", 64'(rsp_valid), 1);
      chk_rsp("cont", k % N, ref_alu(32'(10 * (k % N + 1)), 32'(k % N), 4'h0));
    end
    req_valid = '0;
    step();
    chk("cont_idle", 64'(busy), 0);
    // backpressure
    do_reset();
    put(1, 32'd100, 32'd1, 4'h1);
    #1;
    chk("bp_grant", 64'(req_ready), 64'h2);
    step();
    req_valid = '0;
    put(2, 32'd20, 32'd22, 4'h0);
    #1;
    chk("bp_exec_ready", 64'(req_ready), 0);
    step();
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_valid", 64'(rsp_valid), 1);
      chk_rsp("bp_hold", 1, '{1'b1, 1'b0, 1'b0, 1'b0, 32'd99});
      chk("bp_hold_ready", 64'(req_ready), 0);
      step();
    end
    rsp_ready = 1;
    #1;
    chk("bp_release_grant", 64'(req_ready), 64'h4);
    step();
    req_valid = '0;
    #1;
    chk("bp_once", 64'(rsp_valid), 0);
    step();
    chk("bp_next_valid", 64'(rsp_valid), 1);
    chk_rsp("bp_next", 2, '{1'b0, 1'b0, 1'b0, 1'b0, 32'd42});
    step();
    chk("bp_idle", 64'(busy), 0);
    // reset while in EXEC
    do_reset();
    rsp_ready = 1;
    put(0, 32'd1, 32'd2, 4'h0);
    step();
    req_valid = '0;
    #1;
    chk("mid_exec_busy", 64'(busy), 1);
    rst_n = 0;
    step();
    chk("mid_rst_busy", 64'(busy), 0);
    chk("mid_rst_valid", 64'(rsp_valid), 0);
    rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("mid_no_rsp", 64'(rsp_valid), 0);
    end
    put(1, 32'd4, 32'd4, 4'h0);
    put(3, 32'd9, 32'd9, 4'h0);
    #1;
    chk("mid_first_grant", 64'(req_ready), 64'h2);
    step();
    req_valid = '0;
    step();
    chk_rsp("mid_rsp", 1, '{1'b0, 1'b0, 1'b0, 1'b0, 32'd8});
    step();
    // randomized traffic against a transaction-level model
    do_reset();
    ph = 0;
    mlast = N - 1;
    mid = 0;
    mpid = 0;
    mres = '0;
    mpend = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      #1;
      can = ph == 0 || (ph == 2 && rsp_ready);
      g = -1;
      if (can) for (int k = 1; k <= N; k++) if (g < 0 && req_valid[(mlast + k) % N]) g = (mlast + k) % N;
      chk("rnd_ready", 64'(req_ready), g < 0 ? 64'h0 : 64'(1) << g);
      chk("rnd_busy", 64'(busy), 64'(ph != 0));
      chk("rnd_valid", 64'(rsp_valid), 64'(ph == 2));
      if (ph == 2) chk_rsp("rnd_rsp", mid, mres);
      if (ph == 1) begin
        ph = 2;
        mres = mpend;
        mid = mpid;
      end else if (can) begin
        if (g >= 0) begin
          ph = 1;
          mlast = g;
          mpid = g;
          mpend = ref_alu(req_a[g*W +: W], req_b[g*W +: W], req_op[g*4 +: 4]);
        end else ph = 0;
      end
      step();
      if (g >= 0) req_valid[g] = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) put(i, rnd_opnd(), rnd_opnd(), 4'($urandom_range(0, 5)));
        else if (req_valid[i] && $urandom_range(0, 15) == 0) req_valid[i] = 1'b0;
      end
      rsp_ready = $urandom_range(0, 3) != 0;
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
Shares one instance of the team's parametric ALU (`alu`) between NREQ independent requesters. Each requester gets a valid/ready request port, and the arbiter selects among them round-robin. It registers the selected operands, runs the ALU for one cycle and returns result plus flags on a single valid/ready response port tagged with the requester index. Only one operation is in flight at any time. The block sits between the instruction/issue logic and the shared ALU datapath.

Parameters:
- WIDTH, 32, operand/result width; passed unchanged to the internal ALU.
- NREQ, 4, number of requesters; legal range 2..16.
- IDW (localparam), $clog2(NREQ), width of rsp_id.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept; at most one bit high.
- req_a  input  NREQ*WIDTH  operand A; requester i occupies slice [i*WIDTH +: WIDTH].
- req_b  input  NREQ*WIDTH  operand B; same packing as req_a.
- req_op  input  NREQ*4  ALU opcode; requester i occupies slice [i*4 +: 4].
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_id  output  IDW  index of the requester that owns the response.
- rsp_y  output  WIDTH  ALU result.
- rsp_carry, rsp_overflow, rsp_zero, rsp_negative  output  1 each  ALU flags, registered together with rsp_y.
- busy  output  1  high whenever the state is not IDLE.

Behaviour:
- Reset (rst_n low at a clk edge):
  - state = IDLE; all outputs 0.
  - Operand registers cleared.
  - Round-robin pointer last = NREQ-1, so requester 0 has first priority.
- State IDLE:
  - grant = first i with req_valid[i]=1, searching from (last+1) mod NREQ upward with wrap-around.
  - req_ready[grant] = 1, asserted combinationally. Acceptance occurs on that cycle.
  - On acceptance: capture a, b, op and grant index into registers; last <= grant; go to EXEC.
  - No valid requests: stay IDLE, req_ready = 0.
- State EXEC:
  - ALU inputs are driven only from the operand registers, never directly from req_* ports.
  - At the end of the cycle: register y, carry, overflow, zero, negative and id into the rsp_* outputs; rsp_valid <= 1; go to RESP.
  - req_ready = 0.
- State RESP:
  - rsp_* outputs are held stable while rsp_valid=1 and rsp_ready=0.
  - When rsp_ready=1, the response completes that cycle, and arbitration runs in the same cycle exactly as in IDLE:
    - A grant is found: accept it, go to EXEC, rsp_valid <= 0.
    - No grant: go to IDLE, rsp_valid <= 0.
  - When rsp_ready=0: req_ready = 0.
- Latency: acceptance at cycle T gives rsp_valid=1 at T+2. Peak throughput is one operation per 2 cycles with rsp_ready held high.
- Requester rules: a requester holds req_valid and its a/b/op stable until its req_ready bit is seen high. Dropping req_valid before grant is legal and simply removes it from arbitration.
- Fairness: a continuously requesting requester is granted within NREQ acceptances.
- Flags and op encoding are exactly those of the ALU. The arbiter does no arithmetic. Op map: 4'h0 = ADD, 4'h1 = SUB.
- Reset mid-operation (EXEC or RESP): the transaction is discarded with no response issued; all state and outputs return to reset values.
- Simultaneous events:
  - rsp_ready=1 and new requests in the same RESP cycle: both complete that cycle, with no bubble.
  - req_valid rising in EXEC: not acknowledged until the next IDLE/RESP arbitration.

Test Plan:
- Single request: req 0, a=5, b=3, op=ADD, rsp_ready=1 → req_ready[0] at T; at T+2 rsp_valid=1, rsp_id=0, rsp_y=8, all flags 0.
- Contention: all four req_valid held high with distinct operands → grant order 0,1,2,3,0; rsp_id sequence matches; responses 2 cycles apart.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid → rsp_* outputs unchanged and req_ready=0 throughout; release gives exactly one completion.
- Flags, WIDTH=32:
  - req 2, a=32'h7FFF_FFFF, b=1, ADD → rsp_y=32'h8000_0000, overflow=1, negative=1, zero=0.
  - a=7, b=7, SUB → rsp_y=0, zero=1.
- Reset mid-flight: assert rst_n=0 in EXEC → next cycle busy=0, rsp_valid=0, no response ever issued; the first request after reset from requesters 1 and 3 is granted to 1.
- Back-to-back: rsp_ready=1 with req 1 valid during RESP → req_ready[1]=1 in that same cycle; the next response follows exactly 2 cycles after the previous one.
